// File: rtl/divisor_secuencial_pkg.sv
// ----------------------------------------------------------------------------
// divisor_secuencial_pkg : shared FSM encoding and sizing for the divider
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package divisor_secuencial_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LAST_STEP = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/resta32bits.sv
// ----------------------------------------------------------------------------
// resta32bits : 32-bit subtractor, diff = a - b, c = 1 when a >= b (no borrow)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module resta32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        c
);

  // Two's-complement add of ~b + 1; the carry out is the inverted borrow.
  assign {c, diff} = {1'b0, a} + {1'b0, ~b} + 33'd1;

endmodule

`default_nettype wire

// File: rtl/divisor_secuencial.sv
// ----------------------------------------------------------------------------
// divisor_secuencial : 32-bit unsigned restoring divider, one quotient bit/clk.
// Optional macro DIVISOR_FAST_ZERO_EN: divide-by-zero completes in one cycle.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module divisor_secuencial
  import divisor_secuencial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;

  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   sub_diff;
  logic               sub_c;
  logic               step_ok;

  assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  resta32bits u_resta (
    .a    (shifted),
    .b    (d_q),
    .diff (sub_diff),
    .c    (sub_c)
  );

  // A set R[31] means the true 33-bit partial remainder already exceeds D.
  assign step_ok = r_q[WIDTH-1] | sub_c;

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    div_zero_d  = div_zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          q_d        = dividend;
          d_d        = divisor;
          r_d        = '0;
          cnt_d      = '0;
          div_zero_d = (divisor == '0);
          state_d    = RUN;
`ifdef DIVISOR_FAST_ZERO_EN
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            state_d     = DONE;
          end
`endif
        end
      end

      RUN: begin
        if (step_ok) begin
          r_d = sub_diff;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shifted;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LAST_STEP)) begin
          quotient_d  = q_d;
          remainder_d = r_d;
          state_d     = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      div_zero_q  <= div_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

`default_nettype wire
